memory_bus: RTL

Data-side memory subsystem sitting directly downstream of the single-cycle `cpu` data port: it consumes `memory_address`, `memory_write`, `memory_mask` and `memory_we`, and returns `memory_out` in the same cycle. It contains word-organised data RAM with byte-lane writes, a memory-mapped 32-bit timer with compare interrupt, and a transmit FIFO draining through a valid/ready byte stream. It replaces the plain `ram` instance on the CPU data port.

---
 rtl/memory_bus.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/memory_bus.sv
// Data-side memory subsystem: byte-lane RAM, memory-mapped timer with compare
// interrupt, and a TX byte FIFO drained over a valid/ready stream.
package memory_bus_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
  } memory_mask_t;
endpackage

module memory_bus
  import memory_bus_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  memory_address,
  input  logic [31:0]  memory_write,
  input  memory_mask_t memory_mask,
  input  logic         memory_we,
  output logic [31:0]  memory_out,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] ADDR_COUNT  = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_CTRL   = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0010;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0014;

  logic [1:0]    lane;
  logic          isRam;
  logic [AW-1:0] wordIdx;
  logic          aligned;
  logic [3:0]    laneMask;
  logic          ramAccess;
  logic [31:0]   writeShifted;
  logic [31:0]   ramShifted;
  logic [31:0]   ramLoad;
  logic [31:0]   ram [RAM_WORDS];

  assign lane         = memory_address[1:0];
  assign isRam        = (memory_address[31:AW+2] == '0);
  assign wordIdx      = memory_address[AW+1:2];
  assign ramAccess    = isRam && aligned;
  assign writeShifted = memory_write << {lane, 3'b000};
  assign ramShifted   = ram[wordIdx] >> {lane, 3'b000};

  always_comb begin
    aligned  = 1'b0;
    laneMask = 4'b0000;
    ramLoad  = 32'h0;
    case (memory_mask)
      MEM_BYTE: begin
        aligned  = 1'b1;
        laneMask = 4'b0001 << lane;
        ramLoad  = {24'h0, ramShifted[7:0]};
      end
      MEM_HALFWORD: begin
        aligned  = ~memory_address[0];
        laneMask = 4'b0011 << lane;
        ramLoad  = {16'h0, ramShifted[15:0]};
      end
      MEM_WORD: begin
        aligned  = (lane == 2'b00);
        laneMask = 4'b1111;
        ramLoad  = ramShifted;
      end
      default: ;
    endcase
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (memory_we && ramAccess) begin
      for (int i = 0; i < 4; i++) begin
        if (laneMask[i]) ram[wordIdx][8*i +: 8] <= writeShifted[8*i +: 8];
      end
    end
  end

  logic periWord, selCount, selCmp, selCtrl, selTxData, selStatus;
  logic wrCmp, wrCtrl, wrTxData, wrStatus;

  assign periWord  = (memory_mask == MEM_WORD);
  assign selCount  = periWord && (memory_address == ADDR_COUNT);
  assign selCmp    = periWord && (memory_address == ADDR_CMP);
  assign selCtrl   = periWord && (memory_address == ADDR_CTRL);
  assign selTxData = periWord && (memory_address == ADDR_TXDATA);
  assign selStatus = periWord && (memory_address == ADDR_STATUS);
  assign wrCmp     = memory_we && selCmp;
  assign wrCtrl    = memory_we && selCtrl;
  assign wrTxData  = memory_we && selTxData;
  assign wrStatus  = memory_we && selStatus;

  logic [31:0] timerCount_q, timerCount_d, timerCmp_q, timerCmp_d;
  logic        enable_q, enable_d, pending_q, pending_d, match;

  assign match = enable_q && (timerCount_q == timerCmp_q);

  always_comb begin
    timerCount_d = enable_q ? timerCount_q + 32'd1 : timerCount_q;
    if (wrCtrl && memory_write[2]) timerCount_d = 32'h0;
    timerCmp_d = wrCmp ? memory_write : timerCmp_q;
    enable_d   = wrCtrl ? memory_write[0] : enable_q;
    pending_d  = match | (pending_q & ~(wrCtrl & memory_write[1]));
  end

  logic [7:0]    fifoBuf [FIFO_DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0] fifoCount_q, fifoCount_d;
  logic          overflow_q, overflow_d;
  logic          fifoFull, fifoEmpty, push, pop;

  assign fifoFull  = (fifoCount_q == CW'(FIFO_DEPTH));
  assign fifoEmpty = (fifoCount_q == '0);
  assign push      = wrTxData && !fifoFull;
  assign pop       = !fifoEmpty && tx_ready;

  always_comb begin
    rdPtr_d     = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    wrPtr_d     = push ? wrPtr_q + PW'(1) : wrPtr_q;
    fifoCount_d = fifoCount_q;
    case ({push, pop})
      2'b10:   fifoCount_d = fifoCount_q + CW'(1);
      2'b01:   fifoCount_d = fifoCount_q - CW'(1);
      default: ;
    endcase
    overflow_d = (wrTxData && fifoFull) | (overflow_q & ~(wrStatus & memory_write[2]));
  end

  always_ff @(posedge clk) begin
    if (push) fifoBuf[wrPtr_q] <= memory_write[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timerCount_q <= 32'h0;
      timerCmp_q   <= 32'h0;
      enable_q     <= 1'b0;
      pending_q    <= 1'b0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      fifoCount_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      timerCount_q <= timerCount_d;
      timerCmp_q   <= timerCmp_d;
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      fifoCount_q  <= fifoCount_d;
      overflow_q   <= overflow_d;
    end
  end

  assign tx_valid  = !fifoEmpty;
  assign tx_data   = fifoEmpty ? 8'h00 : fifoBuf[rdPtr_q];
  assign timer_irq = pending_q;

  // Loads see pre-edge state; everything unmapped or misaligned reads zero.
  always_comb begin
    memory_out = 32'h0;
    if (ramAccess)      memory_out = ramLoad;
    else if (selCount)  memory_out = timerCount_q;
    else if (selCmp)    memory_out = timerCmp_q;
    else if (selCtrl)   memory_out = {30'h0, pending_q, enable_q};
    else if (selStatus) memory_out = {16'h0, 8'(fifoCount_q), 5'h0, overflow_q, fifoEmpty, fifoFull};
  end

endmodule
